// File: rtl/yazmac_yazma_hakem.sv
// Write-port arbiter for the 32x32 register file: round-robin between ALU (A) and
// long-latency (B) writeback, plus an optional post-reset clear sweep (YAZMAC_TEMIZLE_EN).
module yazmac_yazma_hakem #(
    parameter int ADR_W  = 5,
    parameter int VERI_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_gecerli_i,
    input  logic [ADR_W-1:0]  a_adr_i,
    input  logic [VERI_W-1:0] a_deger_i,
    output logic              a_hazir_o,
    input  logic              b_gecerli_i,
    input  logic [ADR_W-1:0]  b_adr_i,
    input  logic [VERI_W-1:0] b_deger_i,
    output logic              b_hazir_o,
    output logic              yaz_o,
    output logic [ADR_W-1:0]  yaz_adr_o,
    output logic [VERI_W-1:0] yaz_deger_o,
    output logic              mesgul_o
);

    typedef enum logic {TEMIZLE, CALIS} durum_t;

    durum_t durum;
    logic   oncelik_a;
    logic   mesgul_r;
    logic   a_ver;
    logic   b_ver;

`ifdef YAZMAC_TEMIZLE_EN
    logic [ADR_W-1:0] sayac;
`else
    assign mesgul_r = 1'b0;
`endif

    assign mesgul_o  = mesgul_r;
    assign a_hazir_o = a_ver;
    assign b_hazir_o = b_ver;

    // mesgul_r stays high for the cycle that shows the last sweep write, keeping grants off
    always_comb begin
        a_ver = 1'b0;
        b_ver = 1'b0;
        if (!rst && durum == CALIS && !mesgul_r) begin
            if (a_gecerli_i && (!b_gecerli_i || oncelik_a)) begin
                a_ver = 1'b1;
            end else if (b_gecerli_i) begin
                b_ver = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef YAZMAC_TEMIZLE_EN
            durum    <= TEMIZLE;
            sayac    <= '0;
            mesgul_r <= 1'b0;
`else
            durum    <= CALIS;
`endif
            oncelik_a   <= 1'b1;
            yaz_o       <= 1'b0;
            yaz_adr_o   <= '0;
            yaz_deger_o <= '0;
        end else begin
            yaz_o <= 1'b0;
            case (durum)
`ifdef YAZMAC_TEMIZLE_EN
                TEMIZLE: begin
                    yaz_o       <= 1'b1;
                    yaz_adr_o   <= sayac;
                    yaz_deger_o <= '0;
                    mesgul_r    <= 1'b1;
                    sayac       <= sayac + 1'b1;
                    if (sayac == '1) begin
                        durum <= CALIS;
                    end
                end
`endif
                CALIS: begin
`ifdef YAZMAC_TEMIZLE_EN
                    mesgul_r <= 1'b0;
`endif
                    // Writes to x0 are consumed but never reach the register file
                    if (a_ver) begin
                        yaz_o       <= |a_adr_i;
                        yaz_adr_o   <= a_adr_i;
                        yaz_deger_o <= a_deger_i;
                        oncelik_a   <= 1'b0;
                    end else if (b_ver) begin
                        yaz_o       <= |b_adr_i;
                        yaz_adr_o   <= b_adr_i;
                        yaz_deger_o <= b_deger_i;
                        oncelik_a   <= 1'b1;
                    end
                end
                default: durum <= CALIS;
            endcase
        end
    end

endmodule

// File: tb/tb_yazmac_yazma_hakem.sv
// Scoreboard bench for yazmac_yazma_hakem; covers both YAZMAC_TEMIZLE_EN builds.
module tb_yazmac_yazma_hakem;

    logic        clk;
    logic        rst;
    logic        a_gecerli_i;
    logic [4:0]  a_adr_i;
    logic [31:0] a_deger_i;
    logic        a_hazir_o;
    logic        b_gecerli_i;
    logic [4:0]  b_adr_i;
    logic [31:0] b_deger_i;
    logic        b_hazir_o;
    logic        yaz_o;
    logic [4:0]  yaz_adr_o;
    logic [31:0] yaz_deger_o;
    logic        mesgul_o;

    typedef struct {
        int          cyc;
        logic [4:0]  adr;
        logic [31:0] deger;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    yazmac_yazma_hakem dut (
        .clk(clk), .rst(rst),
        .a_gecerli_i(a_gecerli_i), .a_adr_i(a_adr_i), .a_deger_i(a_deger_i), .a_hazir_o(a_hazir_o),
        .b_gecerli_i(b_gecerli_i), .b_adr_i(b_adr_i), .b_deger_i(b_deger_i), .b_hazir_o(b_hazir_o),
        .yaz_o(yaz_o), .yaz_adr_o(yaz_adr_o), .yaz_deger_o(yaz_deger_o), .mesgul_o(mesgul_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; grant expectations are hand-computed by the caller
    task automatic applyStimulus(input logic av, input logic [4:0] aadr, input logic [31:0] adat,
                                 input logic bv, input logic [4:0] badr, input logic [31:0] bdat,
                                 input logic exp_a, input logic exp_b, input logic exp_m,
                                 input logic chk_nowrite);
        a_gecerli_i = av;
        a_adr_i     = aadr;
        a_deger_i   = adat;
        b_gecerli_i = bv;
        b_adr_i     = badr;
        b_deger_i   = bdat;
        @(negedge clk);
        checkOutput("a_hazir", {31'b0, a_hazir_o}, {31'b0, exp_a});
        checkOutput("b_hazir", {31'b0, b_hazir_o}, {31'b0, exp_b});
        checkOutput("mesgul", {31'b0, mesgul_o}, {31'b0, exp_m});
        if (chk_nowrite) checkOutput("no_write", {31'b0, yaz_o}, 32'd0);
        if (exp_a && aadr != 5'd0) q.push_back('{cyc + 1, aadr, adat});
        else if (exp_b && badr != 5'd0) q.push_back('{cyc + 1, badr, bdat});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic chk_nowrite);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, chk_nowrite);
    endtask

    // Called on the first cycle with rst low; leaves the pointer favouring A
    task automatic prologue();
`ifdef YAZMAC_TEMIZLE_EN
        for (int i = 0; i < 32; i++) q.push_back('{cyc + 1 + i, i[4:0], 32'd0});
        for (int c = 0; c < 33; c++)
            applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h99,
                          1'b0, 1'b0, (c >= 1), (c == 0));
`endif
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

`ifdef YAZMAC_TEMIZLE_EN
    // Let the sweep reach address 10, pulse reset, then drop it again
    task automatic abortSweep();
        for (int i = 0; i < 11; i++) q.push_back('{cyc + 1 + i, i[4:0], 32'd0});
        for (int c = 0; c < 11; c++)
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, (c >= 1), (c == 0));
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
    endtask
`endif

    // Monitor: every write the DUT presents must match the head of the scoreboard
    initial begin
        wr_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (yaz_o === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL wr_unexpected: got write adr %0d data 0x%0h, expected none (cycle %0d)",
                             yaz_adr_o, yaz_deger_o, cyc);
                end else begin
                    e = q.pop_front();
                    checkOutput("wr_cycle", cyc, e.cyc);
                    checkOutput("wr_adr", {27'b0, yaz_adr_o}, {27'b0, e.adr});
                    checkOutput("wr_deger", yaz_deger_o, e.deger);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_adr", {27'b0, yaz_adr_o}, 32'd0);
        checkOutput("rst_deger", yaz_deger_o, 32'd0);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        prologue();

        // Conflict: A, B, then re-asserted A must wait for B's grant
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // x0 writes are consumed without a register-file write
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Reset while in normal operation
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
`ifdef YAZMAC_TEMIZLE_EN
        abortSweep();
        prologue();
`else
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hCC, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCC, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        checkOutput("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/yazmac_yazma_hakem.md
# yazmac_yazma_hakem

Write-port arbiter and sequencer for the 32x32 integer register file. Shares the file's single write port between two writeback sources: A (single-cycle ALU writeback) and B (long-latency unit, e.g. load/mul/div). Also drives a post-reset clear sweep that zeroes all 32 registers. Sits between the writeback stage and the register file's `yaz_adr_i` / `yaz_deger_i` / `yaz` inputs.

## Interface
Parameters:
- `ADR_W`, 5: register address width.
- `VERI_W`, 32: data width.

Ports:
- `clk`  in  1  clock. The block has one clock and uses the rising edge only.
- `rst`  in  1  reset. Synchronous, active-high.
- `a_gecerli_i`  in  1  requester A valid.
- `a_adr_i`  in  ADR_W  requester A destination register.
- `a_deger_i`  in  VERI_W  requester A data.
- `a_hazir_o`  out  1  requester A accepted this cycle.
- `b_gecerli_i`, `b_adr_i`, `b_deger_i`, `b_hazir_o`: same as the A ports, for requester B.
- `yaz_o`  out  1  register-file write enable. Registered.
- `yaz_adr_o`  out  ADR_W  register-file write address. Registered.
- `yaz_deger_o`  out  VERI_W  register-file write data. Registered.
- `mesgul_o`  out  1  clear sweep in progress.

## Operation
- State machine has two states:
  - TEMIZLE: the clear sweep.
  - CALIS: normal arbitration.
- Reset entry:
  - With the sweep compiled in, `rst` forces TEMIZLE with the sweep counter at 0.
  - With the sweep compiled out, `rst` forces CALIS.
- TEMIZLE:
  - Each cycle drives a write of 0 to the address held in the counter, then increments the counter.
  - Address 0 is included in the sweep.
  - After the write to address 31, the state moves to CALIS.
  - `a_hazir_o` and `b_hazir_o` are 0 throughout; `mesgul_o` is 1.
- CALIS handshake:
  - A transfer happens when `x_gecerli_i & x_hazir_o`.
  - A requester must hold valid, address and data stable until accepted.
  - Requesters are never dropped.
- CALIS arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, a round-robin pointer decides: the requester not granted last wins.
  - The pointer updates on every grant.
  - After reset the pointer favours A.
- `x_hazir_o` is combinational from the state, the pointer and both `gecerli` inputs. It is high only for the granted requester.
- x0 rule: an accepted request with address 0 is consumed (hazir=1) but produces `yaz_o`=0, so x0 is never overwritten with nonzero data.
- One write per cycle at most. No buffering; losing requester stalls.

## Timing
- Reset values: `yaz_o`=0, `yaz_adr_o`=0, `yaz_deger_o`=0, `mesgul_o`=0 while `rst`=1.
- `a_hazir_o` and `b_hazir_o` are 0 while `rst`=1.
- Sweep timing:
  - First sweep write appears on the cycle after `rst` falls: `yaz_o`=1, adr 0.
  - The sweep takes 32 cycles.
  - `mesgul_o` drops, and hazir may assert, on cycle 33.
- Write latency: an acceptance in cycle N gives `yaz_o`/`yaz_adr_o`/`yaz_deger_o` in cycle N+1.
- Throughput: back-to-back acceptances give back-to-back writes.
- Reset mid-sweep restarts the sweep at address 0.
- Reset in CALIS discards the registered write. `yaz_o`=0 the next cycle.
- Counter wraps 31→0 only on the transition to CALIS. The counter is never reused in CALIS.

## Configuration
- Macro: `YAZMAC_TEMIZLE_EN`.
- Defined:
  - TEMIZLE state and the 5-bit sweep counter exist.
  - Behaviour is as described above.
- Undefined:
  - No sweep; the block enters CALIS directly after reset.
  - `mesgul_o` is tied to 0.
  - First acceptance is possible on the first cycle after `rst` falls.
  - Register contents are undefined except for writes made after reset.

## Test plan
- Sweep (macro on): `rst` high for 2 cycles, then low.
  - Cycles 1–32: `yaz_o`=1, `yaz_adr_o`=0..31 in order, `yaz_deger_o`=0, `mesgul_o`=1, hazir=0.
  - Cycle 33: `mesgul_o`=0.
- Single A: A valid with adr 5, data 0xDEADBEEF → `a_hazir_o`=1 same cycle; next cycle `yaz_o`=1, adr 5, data 0xDEADBEEF.
- Conflict: A (adr 1, 0x11) and B (adr 2, 0x22) both held valid after sweep.
  - Grants run A, B.
  - Writes: adr 1 then adr 2 on consecutive cycles.
  - A re-asserting with B wins again only after B's grant.
- x0: A valid with adr 0, data 0x1234 → `a_hazir_o`=1; next cycle `yaz_o`=0.
- Reset mid-sweep: `rst` pulse while sweep is at address 10 → after release, sweep restarts at adr 0 and runs the full 32 cycles.
- Macro off: after reset, A valid with adr 3 on the first cycle → accepted immediately; `yaz_o`=1 the next cycle; `mesgul_o` always 0.
